// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle RV32M-style multiply/divide unit: shift-add multiplication and
// restoring division on operand magnitudes, with the sign fix-up applied in a final cycle.
module iterative_muldiv_unit #(
    parameter int OPERAND_LENGTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2:0]                op_select,
    input  logic [OPERAND_LENGTH-1:0] opd1,
    input  logic [OPERAND_LENGTH-1:0] opd2,
    output logic                      busy,
    output logic                      result_valid,
    output logic [OPERAND_LENGTH-1:0] result
);

    localparam int N     = OPERAND_LENGTH;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    state_t           r_state;
    state_t           w_next_state;
    op_t              r_op;
    logic [N-1:0]     r_opd1;
    logic [N-1:0]     r_opd2;
    logic             r_setup;
    logic [CNT_W-1:0] r_counter;
    logic [N-1:0]     r_mag_a;
    logic [N-1:0]     r_mag_b;
    logic [2*N-1:0]   r_prod;
    logic [N-1:0]     r_rem;
    logic [N-1:0]     r_quot;
    logic             r_negate;
    logic [N-1:0]     r_result;

    logic             w_accept;
    logic             w_signed_a;
    logic             w_signed_b;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [N-1:0]     w_mag_a;
    logic [N-1:0]     w_mag_b;
    logic             w_negate;
    logic [N:0]       w_mul_sum;
    logic [N:0]       w_shifted;
    logic [N:0]       w_diff;
    logic             w_q_bit;
    logic [2*N-1:0]   w_prod_fix;
    logic [N-1:0]     w_quot_fix;
    logic [N-1:0]     w_rem_fix;
    logic [N-1:0]     w_final;

    // A new request is taken in IDLE and also in DONE, so back-to-back issue has no gap.
    assign w_accept = start && (r_state != S_CALC);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves the signal unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = S_CALC;
            S_CALC: if (!r_setup && (r_counter == '0)) w_next_state = S_DONE;
            S_DONE: w_next_state = w_accept ? S_CALC : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy         = (r_state == S_CALC);
        result_valid = (r_state == S_DONE);
        result       = (r_state == S_DONE) ? w_final : r_result;
    end

    // The first CALC cycle converts the latched operands to magnitudes and records the result sign.
    always_comb begin
        w_signed_a = !((r_op == OP_MULHU) || (r_op == OP_DIVU) || (r_op == OP_REMU));
        w_signed_b = (r_op == OP_MUL) || (r_op == OP_MULH) || (r_op == OP_DIV) || (r_op == OP_REM);
        w_a_neg    = w_signed_a && r_opd1[N-1];
        w_b_neg    = w_signed_b && r_opd2[N-1];
        w_mag_a    = w_a_neg ? -r_opd1 : r_opd1;
        w_mag_b    = w_b_neg ? -r_opd2 : r_opd2;
        case (r_op)
            OP_DIV:  w_negate = (w_a_neg ^ w_b_neg) && (r_opd2 != '0);
            OP_REM:  w_negate = w_a_neg;
            OP_DIVU,
            OP_REMU: w_negate = 1'b0;
            default: w_negate = w_a_neg ^ w_b_neg;
        endcase
    end

    // One shift-add multiply step and one restoring divide step, both evaluated every iteration.
    always_comb begin
        w_mul_sum = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_mag_a} : '0);
        w_shifted = {r_rem, r_quot[N-1]};
        w_diff    = w_shifted - {1'b0, r_mag_b};
        w_q_bit   = !w_diff[N];
    end

    always_comb begin
        w_prod_fix = r_negate ? -r_prod : r_prod;
        w_quot_fix = r_negate ? -r_quot : r_quot;
        w_rem_fix  = r_negate ? -r_rem  : r_rem;
        case (r_op)
            OP_MUL:  w_final = w_prod_fix[N-1:0];
            OP_MULH,
            OP_MULHSU,
            OP_MULHU: w_final = w_prod_fix[2*N-1:N];
            OP_DIV,
            OP_DIVU: w_final = w_quot_fix;
            default: w_final = w_rem_fix;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= OP_MUL;
            r_opd1    <= '0;
            r_opd2    <= '0;
            r_setup   <= 1'b0;
            r_counter <= '0;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_negate  <= 1'b0;
            r_result  <= '0;
        end else begin
            if (w_accept) begin
                r_op      <= op_t'(op_select);
                r_opd1    <= opd1;
                r_opd2    <= opd2;
                r_setup   <= 1'b1;
                r_counter <= CNT_INIT;
            end else if (r_state == S_CALC) begin
                if (r_setup) begin
                    r_setup  <= 1'b0;
                    r_mag_a  <= w_mag_a;
                    r_mag_b  <= w_mag_b;
                    r_prod   <= {{N{1'b0}}, w_mag_b};
                    r_rem    <= '0;
                    r_quot   <= w_mag_a;
                    r_negate <= w_negate;
                end else begin
                    r_prod    <= {w_mul_sum, r_prod[N-1:1]};
                    r_rem     <= w_q_bit ? w_diff[N-1:0] : w_shifted[N-1:0];
                    r_quot    <= {r_quot[N-2:0], w_q_bit};
                    r_counter <= r_counter - 1'b1;
                end
            end
            if (r_state == S_DONE) r_result <= w_final;
        end
    end

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Self-checking bench for iterative_muldiv_unit: directed test-plan cases, handshake and
// reset scenarios, then random operations checked against an arithmetic reference model.
module tb_iterative_muldiv_unit;

    localparam int N = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    op_select;
    logic [N-1:0]  opd1;
    logic [N-1:0]  opd2;
    logic          busy;
    logic          result_valid;
    logic [N-1:0]  result;

    int n_checks = 0;
    int n_errors = 0;

    iterative_muldiv_unit #(.OPERAND_LENGTH(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op_select    (op_select),
        .opd1         (opd1),
        .opd2         (opd2),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model: RV32M semantics from plain integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint          ub = longint'({32'b0, b});
        longint unsigned uua = {32'b0, a};
        longint unsigned uub = {32'b0, b};
        logic [63:0]     p;
        int              q;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = uua * uub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = $signed(a) / $signed(b);
                return q;
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Presents a request; returns #1 after the accepting edge with start released.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_select = op;
        opd1      = a;
        opd2      = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for result_valid, counting edges and busy-high samples before it.
    task automatic wait_valid(output int edges, output int busy_cnt, output bit seen);
        edges    = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (result_valid) seen = 1'b1;
            else if (busy)    busy_cnt++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expected, input string tag);
        int edges;
        int busy_cnt;
        bit seen;
        int first_busy;
        issue(op, a, b);
        first_busy = int'(busy);
        wait_valid(edges, busy_cnt, seen);
        check({tag, " valid_seen"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(edges), 64'(N + 1));
        check({tag, " busy_cycles"}, 64'(first_busy + busy_cnt), 64'(N + 1));
        check({tag, " busy_in_done"}, 64'(busy), 64'd0);
        check({tag, " result"}, 64'(result), 64'(expected));
        @(posedge clk);
        #1;
        check({tag, " valid_pulse"}, 64'(result_valid), 64'd0);
        check({tag, " result_hold"}, 64'(result), 64'(expected));
    endtask

    initial begin
        int          edges;
        int          busy_cnt;
        int          pre_edges;
        int          n_valid;
        bit          seen;
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [31:0] specials [5];

        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;

        rst       = 1'b1;
        start     = 1'b0;
        op_select = 3'd0;
        opd1      = '0;
        opd2      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset valid", 64'(result_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed test-plan cases with hand-derived expectations.
        run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_-1");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_-1");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_-7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_-7/2");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100/7");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu_100/7");
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        run_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");
        run_op(3'd4, 32'd9, 32'd0, 32'hFFFF_FFFF, "div_by0");

        // start during CALC is ignored; operand changes after acceptance do not matter.
        issue(3'd0, 32'd123, 32'd456);
        repeat (10) @(posedge clk);
        @(negedge clk);
        start     = 1'b1;
        op_select = 3'd4;
        opd1      = 32'h1234_5678;
        opd2      = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        opd1  = 32'hDEAD_BEEF;
        pre_edges = 11;
        wait_valid(edges, busy_cnt, seen);
        check("ignore valid_seen", 64'(seen), 64'd1);
        check("ignore latency", 64'(pre_edges + edges), 64'(N + 1));
        check("ignore result", 64'(result), 64'd56088);
        n_valid = 0;
        for (int i = 0; i < N + 8; i++) begin
            @(posedge clk);
            #1;
            if (result_valid) n_valid++;
        end
        check("ignore no_second_result", 64'(n_valid), 64'd0);

        // Back-to-back: second request raised during the result_valid cycle.
        issue(3'd5, 32'd1000, 32'd7);
        wait_valid(edges, busy_cnt, seen);
        check("b2b first_valid", 64'(seen), 64'd1);
        check("b2b first_result", 64'(result), 64'd142);
        op_select = 3'd7;
        opd1      = 32'd1000;
        opd2      = 32'd7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b accepted_busy", 64'(busy), 64'd1);
        check("b2b valid_drops", 64'(result_valid), 64'd0);
        wait_valid(edges, busy_cnt, seen);
        check("b2b second_valid", 64'(seen), 64'd1);
        check("b2b spacing", 64'(edges + 1), 64'(N + 2));
        check("b2b second_result", 64'(result), 64'd6);
        @(posedge clk);
        #1;

        // Reset during a DIVU aborts it with no result.
        issue(3'd5, 32'hFFFF_0000, 32'd13);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst valid", 64'(result_valid), 64'd0);
        check("midrst result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_valid = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk);
            #1;
            if (result_valid) n_valid++;
        end
        check("midrst no_result", 64'(n_valid), 64'd0);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, "post_rst_mul");

        // Random operations against the reference model, biased toward corner operands.
        for (int t = 0; t < 40; t++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
            r_b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 32'($urandom);
            if ($urandom_range(0, 3) == 0) r_b = 32'($urandom_range(0, 15));
            run_op(r_op, r_a, r_b, model(r_op, r_a, r_b), $sformatf("rand%0d op%0d", t, r_op));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
